router_fifo: RTL

Per-port output buffer of the router: stores bytes emitted by the register stage, tagging the first byte of each packet as a header. It releases them to the destination reader on request. A packet-length counter tracks how many bytes of the current packet remain to be read. When a packet has been fully drained, the data bus returns to 0. Three instances sit between the register stage and the three destination ports; `soft_reset` comes from the synchroniser's read timeout.

---
 rtl/router_fifo.sv | 94 +++++++++
 1 files changed

// File: rtl/router_fifo.sv
// Per-port router output FIFO: 9-bit entries (header flag + byte), wrap-bit
// pointers and a packet-length counter that zeroes data_out once a packet drains.
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       soft_reset,
    input  logic       write_enb,
    input  logic       read_enb,
    input  logic       lfd_state,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       full,
    output logic       empty
);

    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]  count_q, count_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        lfd_q;
    logic        wr_ok_s;
    logic        rd_ok_s;
    logic [8:0]  rd_entry_s;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign wr_ok_s    = write_enb && !full;
    assign rd_ok_s    = read_enb && !empty;
    assign rd_entry_s = mem_q[rd_ptr_q[AW-1:0]];
    assign data_out   = data_out_q;

    // Next-state for pointers, packet counter and read data.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
            data_out_d = rd_entry_s[7:0];
            // Header carries payload length in [7:2]; +1 accounts for the parity byte.
            if (rd_entry_s[8]) begin
                count_d = {1'b0, rd_entry_s[7:2]} + 7'd1;
            end else if (count_q != 7'd0) begin
                count_d = count_q - 7'd1;
            end else begin
                count_d = 7'd0;
            end
        end else if (count_q == 7'd0) begin
            data_out_d = 8'd0;
        end else begin
            data_out_d = data_out_q;
        end
    end

    // Control registers with hard and soft reset.
    always_ff @(posedge clock) begin
        if (reset || soft_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 7'd0;
            data_out_q <= 8'd0;
            lfd_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            lfd_q      <= lfd_state;
        end
    end

    // Storage array; only a hard reset clears its contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 9'd0;
            end
        end else if (!soft_reset && wr_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {lfd_q, data_in};
        end
    end

endmodule
